// File: rtl/frame_dma_if.sv
// frame_dma_if
//   Bundles the capture-FIFO read port and the shared-RAM write port that the
//   frame DMA controller drives.
//   master : the DMA controller (pops the FIFO, requests and writes RAM)
//   slave  : the environment (capture FIFO + RAM arbiter)
//   Signals:
//     fifo_d[31:0]  FIFO head word, valid while fifo_rdy
//     fifo_rdy      FIFO not empty
//     fifo_next     pop FIFO head
//     fifo_ovf      FIFO overflow indication
//     ram_req       request the shared RAM port
//     ram_gnt       RAM port granted
//     ram_valid     write word valid
//     ram_ready     write word accepted
//     ram_addr      RAM byte address
//     ram_wdata     RAM write data
interface frame_dma_if #(
   parameter int ADDR_W = 24
) ();
   logic [31:0]       fifo_d;
   logic              fifo_rdy;
   logic              fifo_next;
   logic              fifo_ovf;
   logic              ram_req;
   logic              ram_gnt;
   logic              ram_valid;
   logic              ram_ready;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;

   modport master (
      input  fifo_d, fifo_rdy, fifo_ovf, ram_gnt, ram_ready,
      output fifo_next, ram_req, ram_valid, ram_addr, ram_wdata
   );

   modport slave (
      output fifo_d, fifo_rdy, fifo_ovf, ram_gnt, ram_ready,
      input  fifo_next, ram_req, ram_valid, ram_addr, ram_wdata
   );
endinterface

// File: rtl/frame_dma_ctrl.sv
// frame_dma_ctrl
//   Sequences one thermal-frame capture into RAM: on start it requests a frame
//   from the capture block, drains the capture FIFO and writes each word to RAM
//   in bursts of up to BURST_LEN words per arbiter grant, reporting progress,
//   completion and errors to the CPU register file.
//   Ports:
//     clk, reset      system clock, asynchronous active-high reset
//     start, abort    1-cycle CPU command pulses
//     cfg_base        RAM byte address of word 0 (sampled at start)
//     cfg_words       32-bit words per frame (sampled at start)
//     busy            controller not idle
//     done            sticky frame-complete flag, cleared by accepted start
//     error[1:0]      sticky {short_frame|timeout, fifo_overflow}
//     words_done      words written this frame
//     frame_req       1-cycle request to the capture block
//     capture_active  capture in progress / data pending
//     bus             FIFO read + RAM write port (frame_dma_if.master)
module frame_dma_ctrl #(
   parameter int ADDR_W    = 24,
   parameter int CNT_W     = 20,
   parameter int BURST_LEN = 8,
   parameter int TIMEOUT   = 1048576
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [CNT_W-1:0]  cfg_words,
   output logic              busy,
   output logic              done,
   output logic [1:0]        error,
   output logic [CNT_W-1:0]  words_done,
   output logic              frame_req,
   input  logic              capture_active,
   frame_dma_if.master       bus
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int BW = $clog2(BURST_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ARB,
      S_BURST,
      S_REL,
      S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  words_q;
   logic [CNT_W-1:0]  wdone_q;
   logic [TW-1:0]     timer_q;
   logic [BW-1:0]     beat_q;
   logic              abort_q;
   logic              done_q;
   logic [1:0]        err_q;

   logic              load;
   logic              xfer;
   logic              tmr_inc;
   logic              set_err1;
   logic              set_done;
   logic              abort_arm;
   logic              fifo_next_c;
   logic              ram_req_c;
   logic              ram_valid_c;
   logic [BW-1:0]     beat_nxt;
   logic [CNT_W-1:0]  wdone_nxt;

   assign beat_nxt  = beat_q + BW'(1);
   assign wdone_nxt = wdone_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      frame_req   = 1'b0;
      fifo_next_c = 1'b0;
      ram_req_c   = 1'b0;
      ram_valid_c = 1'b0;
      load        = 1'b0;
      xfer        = 1'b0;
      tmr_inc     = 1'b0;
      set_err1    = 1'b0;
      set_done    = 1'b0;
      abort_arm   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // abort wins over a simultaneous start
            if (start && !abort) begin
               load = 1'b1;
               if (cfg_words == '0) begin
                  state_d = S_FIN;
               end else begin
                  frame_req = 1'b1;
                  state_d   = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (capture_active) begin
               state_d = S_WAIT;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               set_err1 = 1'b1;
               state_d  = S_FIN;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         S_WAIT: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (bus.fifo_rdy) begin
               state_d = S_ARB;
            end else if (!capture_active && (wdone_q < words_q)) begin
               // capture finished but the frame is short
               set_err1 = 1'b1;
               state_d  = S_FIN;
            end
         end
         S_ARB: begin
            ram_req_c = 1'b1;
            if (abort) begin
               state_d = S_IDLE;
            end else if (bus.ram_gnt) begin
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            ram_req_c   = 1'b1;
            ram_valid_c = bus.fifo_rdy;
            if (bus.fifo_rdy && bus.ram_ready) begin
               xfer        = 1'b1;
               fifo_next_c = 1'b1;
               if (abort || abort_q) begin
                  state_d = S_IDLE;
               end else if ((beat_nxt == BW'(BURST_LEN)) || (wdone_nxt == words_q)) begin
                  state_d = S_REL;
               end
            end else if (!bus.fifo_rdy) begin
               state_d = (abort || abort_q) ? S_IDLE : S_REL;
            end else if (abort) begin
               // a presented word must be accepted before the abort takes effect
               abort_arm = 1'b1;
            end
         end
         S_REL: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (wdone_q == words_q) begin
               state_d = S_FIN;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_FIN: begin
            set_done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         words_q <= '0;
         wdone_q <= '0;
         timer_q <= '0;
         beat_q  <= '0;
         abort_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            addr_q  <= cfg_base;
            words_q <= cfg_words;
            wdone_q <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
         end
         if (tmr_inc) begin
            timer_q <= timer_q + TW'(1);
         end
         if (state_q == S_ARB) begin
            beat_q <= '0;
         end
         if (xfer) begin
            wdone_q <= wdone_nxt;
            addr_q  <= addr_q + ADDR_W'(4);   // wraps modulo 2^ADDR_W
            beat_q  <= beat_nxt;
         end
         if (set_err1) begin
            err_q[1] <= 1'b1;
         end
         if ((state_q != S_IDLE) && bus.fifo_ovf) begin
            err_q[0] <= 1'b1;
         end
         if (set_done) begin
            done_q <= 1'b1;
         end
         abort_q <= (state_d == S_BURST) && (abort_q || abort_arm);
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;
   assign error         = err_q;
   assign words_done    = wdone_q;
   assign bus.fifo_next = fifo_next_c;
   assign bus.ram_req   = ram_req_c;
   assign bus.ram_valid = ram_valid_c;
   assign bus.ram_addr  = addr_q;
   assign bus.ram_wdata = bus.fifo_d;

endmodule
